// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, default control-bundle bit positions,
// FSM states and the alignment rule.
package mem_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam int MEMREAD_BIT_D  = 11;
   localparam int MEMWRITE_BIT_D = 12;
   localparam int SIZE_LSB_D     = 13;
   localparam int SIGNED_BIT_D   = 15;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // The reserved size encoding behaves as a word access.
   function automatic logic isMisaligned(input logic [1:0] addrLo, input logic [1:0] size);
      logic mis;
      case (size)
         SZ_HALF: mis = addrLo[0];
         SZ_BYTE: mis = 1'b0;
         default: mis = (addrLo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension, and the misalignment flag.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  addrLo,
   input  logic [1:0]  size,
   input  logic        signedLoad,
   input  logic [31:0] storeData,
   input  logic [31:0] rawWord,
   output logic [3:0]  byteEn,
   output logic [31:0] wrData,
   output logic [31:0] loadData,
   output logic        misalign
);

   logic [15:0] half_s;
   logic [7:0]  byte_s;

   // Lane selection per access size; a misaligned access touches nothing and reads zero.
   always_comb begin
      misalign = isMisaligned(addrLo, size);
      half_s   = addrLo[1] ? rawWord[31:16] : rawWord[15:0];
      byte_s   = 8'(rawWord >> {addrLo, 3'b000});
      byteEn   = 4'b0000;
      wrData   = storeData;
      loadData = rawWord;
      case (size)
         SZ_HALF: begin
            byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
            wrData   = {2{storeData[15:0]}};
            loadData = {{16{signedLoad & half_s[15]}}, half_s};
         end
         SZ_BYTE: begin
            byteEn   = 4'b0001 << addrLo;
            wrData   = {4{storeData[7:0]}};
            loadData = {{24{signedLoad & byte_s[7]}}, byte_s};
         end
         default: begin
            byteEn   = 4'b1111;
            wrData   = storeData;
            loadData = rawWord;
         end
      endcase
      if (misalign) begin
         byteEn   = 4'b0000;
         loadData = 32'd0;
      end else begin
         byteEn   = byteEn;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data memory with sub-word access, optional wait states with a
// stall handshake, and a registered MEM/WB bundle.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int MEM_WORDS    = 256,
   parameter int WAIT_CYCLES  = 0,
   parameter int CTRL_W       = 32,
   parameter int MEMREAD_BIT  = MEMREAD_BIT_D,
   parameter int MEMWRITE_BIT = MEMWRITE_BIT_D,
   parameter int SIZE_LSB     = SIZE_LSB_D,
   parameter int SIGNED_BIT   = SIGNED_BIT_D
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              iValid,
   input  logic              iFlush,
   input  logic [31:0]       iResult,
   input  logic [CTRL_W-1:0] iControlSignal,
   input  logic [31:0]       iDatabusB,
   input  logic [4:0]        iRegAddress,
   input  logic [31:0]       iPC_plus_4,
   output logic              oStall,
   output logic              oValid,
   output logic [31:0]       oResult,
   output logic [CTRL_W-1:0] oControlSignal,
   output logic [4:0]        oRegAddress,
   output logic [31:0]       oReadData,
   output logic [31:0]       oPC_plus_4,
   output logic              oMisalign
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [31:0]   mem_r [MEM_WORDS];
   logic [0:0]    state_r, stateNext_s;
   logic [3:0]    cnt_r, cntNext_s;
   logic          stall_s, commit_s, storeEn_s;
   logic          memRead_s, memWrite_s, memOp_s, isLoad_s, signed_s, inRange_s;
   logic [1:0]    size_s;
   logic [AW-1:0] index_s;
   logic [31:0]   rawWord_s, wrData_s, alignLoad_s, readData_s;
   logic [3:0]    byteEn_s;
   logic          misalign_s;

   assign memRead_s  = iControlSignal[MEMREAD_BIT];
   assign memWrite_s = iControlSignal[MEMWRITE_BIT];
   assign size_s     = iControlSignal[SIZE_LSB+1:SIZE_LSB];
   assign signed_s   = iControlSignal[SIGNED_BIT];
   assign memOp_s    = memRead_s | memWrite_s;
   assign isLoad_s   = memRead_s & ~memWrite_s;
   assign index_s    = iResult[AW+1:2];
   assign inRange_s  = (iResult[31:AW+2] == {(30-AW){1'b0}});
   assign rawWord_s  = mem_r[index_s];

   mem_lane_align uAlign (
      .addrLo     (iResult[1:0]),
      .size       (size_s),
      .signedLoad (signed_s),
      .storeData  (iDatabusB),
      .rawWord    (rawWord_s),
      .byteEn     (byteEn_s),
      .wrData     (wrData_s),
      .loadData   (alignLoad_s),
      .misalign   (misalign_s)
   );

   // Wait-state FSM: decides stall, commit and next state/counter.
   always_comb begin
      stall_s     = 1'b0;
      commit_s    = 1'b0;
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (iValid && !iFlush) begin
               if (memOp_s && !misalign_s && (WAIT_CYCLES != 0)) begin
                  stall_s     = 1'b1;
                  stateNext_s = ST_WAIT;
                  cntNext_s   = CNT_LOAD;
               end else begin
                  commit_s = 1'b1;
               end
            end else begin
               commit_s = 1'b0;
            end
         end
         ST_WAIT: begin
            if (iFlush) begin
               stateNext_s = ST_IDLE;
               cntNext_s   = 4'd0;
            end else if (cnt_r != 4'd0) begin
               stall_s   = 1'b1;
               cntNext_s = cnt_r - 4'd1;
            end else begin
               commit_s    = 1'b1;
               stateNext_s = ST_IDLE;
            end
         end
         default: begin
            stateNext_s = ST_IDLE;
            cntNext_s   = 4'd0;
         end
      endcase
   end

   // Stall is combinational back to the pipeline but forced low while in reset.
   assign oStall     = stall_s & reset;
   assign storeEn_s  = commit_s & iValid & memWrite_s & ~misalign_s & inRange_s & reset;
   assign readData_s = (commit_s & isLoad_s & inRange_s) ? alignLoad_s : 32'd0;

   // Data memory write port with byte enables; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (storeEn_s) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn_s[b]) begin
               mem_r[index_s][8*b +: 8] <= wrData_s[8*b +: 8];
            end
         end
      end
   end

   // FSM state, wait counter and the MEM/WB output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         cnt_r          <= 4'd0;
         oValid         <= 1'b0;
         oResult        <= 32'd0;
         oControlSignal <= {CTRL_W{1'b0}};
         oRegAddress    <= 5'd0;
         oReadData      <= 32'd0;
         oPC_plus_4     <= 32'd0;
         oMisalign      <= 1'b0;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
         oValid  <= commit_s & iValid;
         if (commit_s) begin
            oResult        <= iResult;
            oControlSignal <= iControlSignal;
            oRegAddress    <= iRegAddress;
            oReadData      <= readData_s;
            oPC_plus_4     <= iPC_plus_4;
            oMisalign      <= memOp_s & misalign_s;
         end
      end
   end

endmodule
